// File: rtl/mix_column_scheduler.sv
// Column scheduler for a shared pipelined MixColumns unit.
// Splits a 128-bit state into columns, tracks them, reassembles.
module mix_column_scheduler #(
  parameter int WORD_SIZE  = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int MC_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*WORD_SIZE-1:0] in_state,
  input  logic                   in_bypass,
  output logic [WORD_SIZE-1:0]   col_out,
  input  logic [WORD_SIZE-1:0]   col_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*WORD_SIZE-1:0] out_state,
  output logic                   busy
);

  localparam int COL_BYTES = WORD_SIZE / BYTE_SIZE;
  localparam int COL_STEP  = COL_BYTES * BYTE_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e                 st_q;
  logic [1:0]             k_q;
  logic [2:0]             cap_q;
  logic [4*WORD_SIZE-1:0] data_q;
  logic [4*WORD_SIZE-1:0] out_q;
  logic                   tag_v_q [MC_LATENCY];
  logic [1:0]             tag_i_q [MC_LATENCY];

  logic                   cap_en;
  logic [1:0]             cap_idx;

  assign cap_en    = tag_v_q[MC_LATENCY-1];
  assign cap_idx   = tag_i_q[MC_LATENCY-1];
  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == HOLD);
  assign busy      = (st_q != IDLE);
  assign out_state = out_q;

  // Drive the current column only while feeding; zero keeps the unit quiet.
  always_comb begin
    col_out = '0;
    if (st_q == FEED)
      col_out = data_q[COL_STEP*(3-int'(k_q)) +: WORD_SIZE];
  end

  // Sequencer, tag pipeline and result reassembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      k_q    <= '0;
      cap_q  <= '0;
      data_q <= '0;
      out_q  <= '0;
      for (int i = 0; i < MC_LATENCY; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_i_q[i] <= '0;
      end
    end else begin
      tag_v_q[0] <= (st_q == FEED);
      tag_i_q[0] <= k_q;
      for (int i = 1; i < MC_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_i_q[i] <= tag_i_q[i-1];
      end
      if (cap_en) begin
        out_q[COL_STEP*(3-int'(cap_idx)) +: WORD_SIZE] <= col_in;
        cap_q <= cap_q + 3'd1;
      end
      unique case (st_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_state;
            k_q    <= '0;
            cap_q  <= '0;
            if (in_bypass) begin
              out_q <= in_state;
              st_q  <= HOLD;
            end else begin
              st_q  <= FEED;
            end
          end
        end
        FEED: begin
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3)
            st_q <= DRAIN;
        end
        DRAIN: begin
          if (cap_en && cap_q == 3'd3)
            st_q <= HOLD;
        end
        HOLD: begin
          if (out_ready)
            st_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_column_scheduler.sv
// Bench for mix_column_scheduler: three instances at latencies 4, 1, 15,
// each driving a MixColumns column model with matching pipeline depth.
module tb_mix_column_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_bypass = 1'b0;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         busy_w      [3];
  logic [31:0]  col_out_w   [3];
  logic [31:0]  col_in_w    [3];
  logic [127:0] out_state_w [3];

  int n_checks = 0;
  int n_err    = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mc_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mc_state(input logic [127:0] s);
    return {mc_col(s[127:96]), mc_col(s[95:64]),
            mc_col(s[63:32]), mc_col(s[31:0])};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 4 : ((g == 1) ? 1 : 15);
    logic [31:0] pipe [LAT];

    always_ff @(posedge clk) begin
      pipe[0] <= col_out_w[g];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign col_in_w[g] = mc_col(pipe[LAT-1]);

    mix_column_scheduler #(
      .WORD_SIZE(32), .BYTE_SIZE(8), .MC_LATENCY(LAT)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid[g]),
      .in_ready(in_ready_w[g]),
      .in_state(in_state),
      .in_bypass(in_bypass),
      .col_out(col_out_w[g]),
      .col_in(col_in_w[g]),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready[g]),
      .out_state(out_state_w[g]),
      .busy(busy_w[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; d selects the instance.
  task automatic run(input int d, input logic [127:0] st,
                     input bit byp, input int hold);
    logic [127:0] cols, want, held;
    int n;
    bit seen;
    int lat;
    lat = byp ? 1 : 5 + lat_of(d);
    in_state    = st;
    in_bypass   = byp;
    in_valid[d] = 1'b1;
    #1 chk("in_ready_idle", 128'(in_ready_w[d]), 128'd1);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_bypass   = ~byp;
    in_state    = ~st;
    exp_q.push_back(byp ? st : mc_state(st));
    cols = '0;
    seen = 1'b0;
    n = 1;
    while (n <= 40) begin
      if (n <= 4) cols[(4-n)*32 +: 32] = col_out_w[d];
      if (out_valid_w[d]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", 128'(seen), 128'd1);
    chk("latency", 128'(n), 128'(lat));
    chk("col_seq", cols, byp ? 128'd0 : st);
    want = exp_q.pop_front();
    chk("out_state", out_state_w[d], want);
    held = out_state_w[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(out_valid_w[d]), 128'd1);
      chk("hold_state", out_state_w[d], held);
      chk("hold_in_ready", 128'(in_ready_w[d]), 128'd0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("post_hs_in_ready", 128'(in_ready_w[d]), 128'd1);
    chk("post_hs_valid", 128'(out_valid_w[d]), 128'd0);
  endtask

  localparam logic [127:0] FIPS = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_MC = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] BYP = 128'h00112233_44556677_8899aabb_ccddeeff;

  initial begin
    bit stray;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
    end
    // Reset with random inputs.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      in_bypass = 1'($urandom);
      for (int d = 0; d < 3; d++) begin
        in_valid[d]  = 1'($urandom);
        out_ready[d] = 1'($urandom);
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 128'(in_ready_w[d]), 128'd1);
      chk("rst_out_valid", 128'(out_valid_w[d]), 128'd0);
      chk("rst_busy", 128'(busy_w[d]), 128'd0);
      chk("rst_col_out", 128'(col_out_w[d]), 128'd0);
      chk("rst_out_state", out_state_w[d], 128'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
    end
    rst_n = 1'b1;
    #1;
    chk("rel_busy", 128'(busy_w[0]), 128'd0);
    chk("rel_out_state", out_state_w[0], 128'd0);
    @(negedge clk);

    // FIPS-197 vector, default latency.
    run(0, FIPS, 1'b0, 0);
    // Bypass round.
    run(0, BYP, 1'b1, 0);
    // Backpressure, then immediate back-to-back accept.
    run(0, FIPS, 1'b0, 20);
    run(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);

    // Reset in the middle of draining.
    in_state    = BYP;
    in_bypass   = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy_w[0]), 128'd0);
    chk("abort_in_ready", 128'(in_ready_w[0]), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid_w[0]) stray = 1'b1;
    end
    chk("abort_no_valid", 128'(stray), 128'd0);
    chk("abort_out_state", out_state_w[0], 128'd0);
    run(0, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1'b0, 0);

    // Latency sweep.
    run(1, FIPS, 1'b0, 0);
    run(2, FIPS, 1'b0, 0);
    chk("fips_model", mc_state(FIPS), FIPS_MC);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
